// File: rtl/gtfwizard_0_rx_delay_powergood.sv
// Holds the GTF RX in reset/power-down until powergood settles, runs one RX reset sequence, then hands control to the user.
// Outputs are registered on state entry; in DONE the GT controls are a combinational mux of the USER inputs; there is no backpressure.
module gtfwizard_0_rx_delay_powergood #(
    parameter int C_USER_GTPOWERGOOD_DELAY_EN = 0,
    parameter int C_PWRGOOD_WAIT_CYCLES       = 256,
    parameter int C_RST_HOLD_CYCLES           = 16,
    parameter int C_RESETDONE_TIMEOUT         = 65535,
    parameter int C_MAX_RETRY                 = 3
) (
    input  logic       GT_RXOUTCLKPCS,
    input  logic       GT_GTPOWERGOOD,
    input  logic       USER_GTRXRESET,
    input  logic       USER_RXPMARESET,
    input  logic [1:0] USER_RXPD,
    input  logic       GT_RXPMARESETDONE,
    input  logic       GT_RXRESETDONE,
    output logic       USER_GTPOWERGOOD,
    output logic       USER_RXRESETDONE,
    output logic       GT_GTRXRESET,
    output logic       GT_RXPMARESET,
    output logic [1:0] GT_RXPD,
    output logic       RX_SEQ_ERROR
);

    generate
        if (C_USER_GTPOWERGOOD_DELAY_EN == 0) begin : g_pass
            logic unused_pt;
            assign unused_pt        = GT_RXOUTCLKPCS ^ GT_RXPMARESETDONE;
            assign GT_GTRXRESET     = USER_GTRXRESET;
            assign GT_RXPMARESET    = USER_RXPMARESET;
            assign GT_RXPD          = USER_RXPD;
            assign USER_GTPOWERGOOD = GT_GTPOWERGOOD;
            assign USER_RXRESETDONE = GT_RXRESETDONE;
            assign RX_SEQ_ERROR     = 1'b0;
        end else begin : g_seq
            localparam int WAIT_W = $clog2(C_PWRGOOD_WAIT_CYCLES + 1);
            localparam int HOLD_W = $clog2(C_RST_HOLD_CYCLES + 1);
            localparam int TO_W   = $clog2(C_RESETDONE_TIMEOUT + 1);
            localparam int RTY_W  = (C_MAX_RETRY > 0) ? $clog2(C_MAX_RETRY + 1) : 1;

            localparam logic [2:0] S_WAIT_PG  = 3'd0;
            localparam logic [2:0] S_HOLD_RST = 3'd1;
            localparam logic [2:0] S_WAIT_PMA = 3'd2;
            localparam logic [2:0] S_WAIT_RST = 3'd3;
            localparam logic [2:0] S_DONE     = 3'd4;
            localparam logic [2:0] S_FAIL     = 3'd5;

            logic [4:0] pg_sr_q;
            (* ASYNC_REG = "TRUE" *) logic [2:0] pma_sync_q;
            (* ASYNC_REG = "TRUE" *) logic [2:0] rst_sync_q;

            logic [2:0]        state_q, state_d;
            logic [WAIT_W-1:0] wait_q, wait_d;
            logic [HOLD_W-1:0] hold_q, hold_d;
            logic [TO_W-1:0]   to_q, to_d;
            logic [RTY_W-1:0]  rty_q, rty_d;
            logic              gtrxreset_q, gtrxreset_d;
            logic [1:0]        rxpd_q, rxpd_d;
            logic              done_q, done_d;
            logic              err_q, err_d;
            logic              timeout;

            logic pg_sync, pma_sync, rst_sync;
            assign pg_sync  = pg_sr_q[4];
            assign pma_sync = pma_sync_q[2];
            assign rst_sync = rst_sync_q[2];

            always_comb begin
                state_d = state_q;
                wait_d  = wait_q;
                hold_d  = hold_q;
                to_d    = to_q;
                rty_d   = rty_q;
                timeout = 1'b0;
                case (state_q)
                    S_WAIT_PG: begin
                        if (pg_sync) begin
                            if (wait_q == WAIT_W'(C_PWRGOOD_WAIT_CYCLES - 1)) state_d = S_HOLD_RST;
                            else wait_d = wait_q + 1'b1;
                        end
                    end
                    S_HOLD_RST: begin
                        if (hold_q == HOLD_W'(C_RST_HOLD_CYCLES - 1)) state_d = S_WAIT_PMA;
                        else hold_d = hold_q + 1'b1;
                    end
                    S_WAIT_PMA: begin
                        // done is tested before the timeout so a coincident done wins
                        if (pma_sync) state_d = S_WAIT_RST;
                        else if (to_q == TO_W'(C_RESETDONE_TIMEOUT - 1)) timeout = 1'b1;
                        else to_d = to_q + 1'b1;
                    end
                    S_WAIT_RST: begin
                        if (rst_sync) state_d = S_DONE;
                        else if (to_q == TO_W'(C_RESETDONE_TIMEOUT - 1)) timeout = 1'b1;
                        else to_d = to_q + 1'b1;
                    end
                    default: ;
                endcase
                if (timeout) begin
                    if (rty_q < RTY_W'(C_MAX_RETRY)) begin
                        rty_d   = rty_q + 1'b1;
                        state_d = S_HOLD_RST;
                    end else begin
                        state_d = S_FAIL;
                    end
                end
                if (state_d != state_q) begin
                    hold_d = '0;
                    to_d   = '0;
                end
            end

            // Output registers follow the next state so they change on the entry edge
            always_comb begin
                gtrxreset_d = 1'b1;
                rxpd_d      = 2'b11;
                done_d      = 1'b0;
                err_d       = 1'b0;
                case (state_d)
                    S_HOLD_RST: rxpd_d = 2'b00;
                    S_WAIT_PMA, S_WAIT_RST: begin
                        rxpd_d      = 2'b00;
                        gtrxreset_d = 1'b0;
                    end
                    S_DONE: done_d = 1'b1;
                    S_FAIL: err_d  = 1'b1;
                    default: ;
                endcase
            end

            always_ff @(posedge GT_RXOUTCLKPCS or negedge GT_GTPOWERGOOD) begin
                if (!GT_GTPOWERGOOD) begin
                    pg_sr_q     <= '0;
                    pma_sync_q  <= '0;
                    rst_sync_q  <= '0;
                    state_q     <= S_WAIT_PG;
                    wait_q      <= '0;
                    hold_q      <= '0;
                    to_q        <= '0;
                    rty_q       <= '0;
                    gtrxreset_q <= 1'b1;
                    rxpd_q      <= 2'b11;
                    done_q      <= 1'b0;
                    err_q       <= 1'b0;
                end else begin
                    pg_sr_q     <= {pg_sr_q[3:0], 1'b1};
                    pma_sync_q  <= {pma_sync_q[1:0], GT_RXPMARESETDONE};
                    rst_sync_q  <= {rst_sync_q[1:0], GT_RXRESETDONE};
                    state_q     <= state_d;
                    wait_q      <= wait_d;
                    hold_q      <= hold_d;
                    to_q        <= to_d;
                    rty_q       <= rty_d;
                    gtrxreset_q <= gtrxreset_d;
                    rxpd_q      <= rxpd_d;
                    done_q      <= done_d;
                    err_q       <= err_d;
                end
            end

            assign GT_GTRXRESET     = done_q ? USER_GTRXRESET  : gtrxreset_q;
            assign GT_RXPMARESET    = done_q ? USER_RXPMARESET : 1'b0;
            assign GT_RXPD          = done_q ? USER_RXPD       : rxpd_q;
            assign USER_GTPOWERGOOD = done_q;
            assign USER_RXRESETDONE = done_q & rst_sync;
            assign RX_SEQ_ERROR     = err_q;
        end
    endgenerate

endmodule

// File: tb/tb_gtfwizard_0_rx_delay_powergood.sv
// Bench for the RX powergood delay block: passthrough vectors plus a sequenced instance against a timeline model.
module tb_gtfwizard_0_rx_delay_powergood;
    localparam int WAIT = 8;
    localparam int HOLD = 4;
    localparam int TMO  = 32;
    localparam int MAXR = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic pg = 1'b1, ur = 1'b0, upr = 1'b0, pma = 1'b0, rdn = 1'b0;
    logic [1:0] upd = 2'b00;
    logic o_upg, o_rdn, o_rst, o_pmar, o_err;
    logic [1:0] o_pd;
    logic [6:0] o_bus;
    assign o_bus = {o_upg, o_rdn, o_rst, o_pmar, o_pd, o_err};

    logic pt_pg = 1'b0, pt_ur = 1'b0, pt_upr = 1'b0, pt_pma = 1'b0, pt_rdn = 1'b0;
    logic [1:0] pt_upd = 2'b00;
    logic pt_upg, pt_ordn, pt_rst, pt_pmar, pt_err;
    logic [1:0] pt_pd;
    logic [6:0] pt_bus;
    assign pt_bus = {pt_upg, pt_ordn, pt_rst, pt_pmar, pt_pd, pt_err};

    gtfwizard_0_rx_delay_powergood #(
        .C_USER_GTPOWERGOOD_DELAY_EN(1), .C_PWRGOOD_WAIT_CYCLES(WAIT), .C_RST_HOLD_CYCLES(HOLD),
        .C_RESETDONE_TIMEOUT(TMO), .C_MAX_RETRY(MAXR)
    ) u_seq (
        .GT_RXOUTCLKPCS(clk), .GT_GTPOWERGOOD(pg), .USER_GTRXRESET(ur), .USER_RXPMARESET(upr),
        .USER_RXPD(upd), .GT_RXPMARESETDONE(pma), .GT_RXRESETDONE(rdn), .USER_GTPOWERGOOD(o_upg),
        .USER_RXRESETDONE(o_rdn), .GT_GTRXRESET(o_rst), .GT_RXPMARESET(o_pmar), .GT_RXPD(o_pd),
        .RX_SEQ_ERROR(o_err)
    );

    gtfwizard_0_rx_delay_powergood #(.C_USER_GTPOWERGOOD_DELAY_EN(0)) u_pt (
        .GT_RXOUTCLKPCS(clk), .GT_GTPOWERGOOD(pt_pg), .USER_GTRXRESET(pt_ur), .USER_RXPMARESET(pt_upr),
        .USER_RXPD(pt_upd), .GT_RXPMARESETDONE(pt_pma), .GT_RXRESETDONE(pt_rdn), .USER_GTPOWERGOOD(pt_upg),
        .USER_RXRESETDONE(pt_ordn), .GT_GTRXRESET(pt_rst), .GT_RXPMARESET(pt_pmar), .GT_RXPD(pt_pd),
        .RX_SEQ_ERROR(pt_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b want=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: phases with entry timestamps; a done input is seen three edges after it is sampled
    typedef enum int {M_PG, M_HOLD, M_PMA, M_RST, M_DONE, M_FAIL} mph_t;
    mph_t m_ph = M_PG;
    int   m_k = 0, m_entry = 0, m_tos = 0;
    logic qp[$];
    logic qr[$];

    task automatic model_reset();
        m_ph = M_PG; m_k = 0; m_entry = 0; m_tos = 0;
        qp.delete(); qr.delete();
    endtask

    task automatic model_step();
        logic sp, sr;
        bit   tmo;
        sp = (qp.size() == 3) ? qp[0] : 1'b0;
        sr = (qr.size() == 3) ? qr[0] : 1'b0;
        qp.push_back(pma);
        qr.push_back(rdn);
        if (qp.size() > 3) void'(qp.pop_front());
        if (qr.size() > 3) void'(qr.pop_front());
        m_k++;
        tmo = 1'b0;
        case (m_ph)
            M_PG:   if (m_k == 5 + WAIT) begin m_ph = M_HOLD; m_entry = m_k; end
            M_HOLD: if (m_k - m_entry == HOLD) begin m_ph = M_PMA; m_entry = m_k; end
            M_PMA:  if (sp) begin m_ph = M_RST; m_entry = m_k; end
                    else if (m_k - m_entry == TMO) tmo = 1'b1;
            M_RST:  if (sr) m_ph = M_DONE;
                    else if (m_k - m_entry == TMO) tmo = 1'b1;
            default: ;
        endcase
        if (tmo) begin
            if (m_tos < MAXR) begin m_tos++; m_ph = M_HOLD; m_entry = m_k; end
            else m_ph = M_FAIL;
        end
    endtask

    function automatic logic [6:0] model_exp();
        logic sync_r;
        sync_r = (qr.size() == 3) ? qr[0] : 1'b0;
        case (m_ph)
            M_PG:         return 7'b0010110;
            M_HOLD:       return 7'b0010000;
            M_PMA, M_RST: return 7'b0000000;
            M_DONE:       return {1'b1, sync_r, ur, upr, upd, 1'b0};
            default:      return 7'b0010111;
        endcase
    endfunction

    int gt_mode = 1, attempt = 0, cyc = 0, d_pma = 0, d_rst = 0;
    int hold_len = 0, pulses = 0, upg_rises = 0, tick_no = 0;
    bit in_att = 1'b0;
    logic prev_rst = 1'b1, prev_upg = 1'b0;

    task automatic tick();
        @(posedge clk);
        if (pg) model_step();
        #1;
        chk("seq_out", o_bus, model_exp());
        tick_no++;
        if (o_upg && !prev_upg) upg_rises++;
        prev_upg = o_upg;
        if (o_pd == 2'b00 && o_rst && !o_upg) hold_len++;
        else if (hold_len != 0) begin
            pulses++;
            chk_int("hold_len", hold_len, HOLD);
            hold_len = 0;
        end
        // GT responder: done flags rise a chosen number of cycles after GTRXRESET falls
        if (!o_upg && prev_rst && !o_rst) begin
            attempt++; in_att = 1'b1; cyc = 0;
            case (gt_mode)
                1: begin d_pma = 10; d_rst = 20; end
                2: begin d_pma = (attempt == 1) ? 1000 : 10; d_rst = 20; end
                3: begin d_pma = 1000; d_rst = 0; end
                default: begin d_pma = $urandom_range(0, 40); d_rst = $urandom_range(0, 40); end
            endcase
        end else if (in_att) cyc++;
        prev_rst = o_rst;
        if (gt_mode == 4) begin pma = 1'b1; rdn = 1'b1; end
        else if (o_rst && !o_upg) begin pma = 1'b0; rdn = 1'b0; in_att = 1'b0; end
        else if (in_att) begin pma = (cyc >= d_pma); rdn = (cyc >= d_pma + d_rst); end
        ur  = 1'($urandom);
        upr = 1'($urandom);
        upd = 2'($urandom);
    endtask

    task automatic drop_pg(input string tag);
        pg = 1'b0;
        model_reset();
        hold_len = 0;
        #1;
        chk({tag, "_async_rst"}, o_bus, 7'b0010110);
        repeat (3) tick();
        pg = 1'b1; attempt = 0; in_att = 1'b0;
    endtask

    task automatic wait_upg(input string tag, input int budget);
        int n;
        n = 0;
        while (!o_upg && n < budget) begin tick(); n++; end
        chk_int({tag, "_reach_done"}, int'(o_upg), 1);
    endtask

    typedef struct {
        logic pg, pma, rdn, ur, upr;
        logic [1:0] upd;
        logic [6:0] exp;
    } pt_vec_t;

    initial begin
        pt_vec_t vt[8];
        int fall_t, done_t;
        vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 7'b0000000};
        vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 7'b1000000};
        vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 7'b0100000};
        vt[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 7'b0010000};
        vt[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 7'b0001000};
        vt[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 7'b0000100};
        vt[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 7'b1000010};
        vt[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 7'b1111110};
        #2;
        for (int i = 0; i < 8; i++) begin
            pt_pg = vt[i].pg; pt_pma = vt[i].pma; pt_rdn = vt[i].rdn;
            pt_ur = vt[i].ur; pt_upr = vt[i].upr; pt_upd = vt[i].upd;
            #1;
            chk($sformatf("pt_vec%0d", i), pt_bus, vt[i].exp);
        end
        for (int i = 0; i < 40; i++) begin
            pt_pg = 1'($urandom); pt_pma = 1'($urandom); pt_rdn = 1'($urandom);
            pt_ur = 1'($urandom); pt_upr = 1'($urandom); pt_upd = 2'($urandom);
            #1;
            chk("pt_rand", pt_bus, {pt_pg, pt_rdn, pt_ur, pt_upr, pt_upd, 1'b0});
        end

        // Nominal sequence with explicit edge positions
        gt_mode = 1;
        drop_pg("init");
        upg_rises = 0; pulses = 0;
        repeat (12) tick();
        chk_int("nom_pd_edge12", int'(o_pd), 3);
        tick();
        chk_int("nom_pd_edge13", int'(o_pd), 0);
        chk_int("nom_rst_edge13", int'(o_rst), 1);
        repeat (3) tick();
        chk_int("nom_rst_edge16", int'(o_rst), 1);
        tick();
        chk_int("nom_rst_edge17", int'(o_rst), 0);
        wait_upg("nom", 100);
        repeat (50) tick();
        chk_int("nom_upg_rises", upg_rises, 1);
        chk_int("nom_pulses", pulses, 1);

        gt_mode = 2;
        drop_pg("to1");
        pulses = 0;
        wait_upg("to1", 300);
        chk_int("to1_pulses", pulses, 2);
        chk_int("to1_err", int'(o_err), 0);

        // Drops in WAIT_RST and in DONE, each followed by a full replay
        gt_mode = 1;
        drop_pg("pre_wrst");
        repeat (37) tick();
        chk("wrst_phase", o_bus, 7'b0000000);
        drop_pg("wrst");
        pulses = 0;
        wait_upg("wrst_replay", 200);
        chk_int("wrst_replay_pulses", pulses, 1);
        repeat (5) tick();
        drop_pg("done");
        wait_upg("done_replay", 200);

        gt_mode = 3;
        drop_pg("fail0");
        pulses = 0;
        repeat (250) tick();
        chk_int("fail_pulses", pulses, MAXR + 1);
        chk("fail_state", o_bus, 7'b0010111);
        repeat (100) tick();
        chk("fail_held", o_bus, 7'b0010111);
        drop_pg("fail");
        pulses = 0;
        repeat (250) tick();
        chk_int("fail_replay_pulses", pulses, MAXR + 1);
        chk("fail_replay_state", o_bus, 7'b0010111);

        // Both done flags already high when WAIT_PMA is entered
        gt_mode = 4;
        drop_pg("pre");
        fall_t = -1; done_t = -1;
        for (int i = 0; i < 100 && done_t < 0; i++) begin
            tick();
            if (fall_t < 0 && !o_rst) fall_t = tick_no;
            if (o_upg) done_t = tick_no;
        end
        chk_int("pre_done_gap", done_t - fall_t, 2);

        gt_mode = 0;
        for (int r = 0; r < 25; r++) begin
            drop_pg("rnd");
            for (int i = 0; i < 300; i++) begin
                tick();
                if ($urandom_range(0, 249) == 0) drop_pg("rnd_mid");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
